// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU instruction controller: opcodes, FSM state
// encoding and default sizing.
package alu_ctrl_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREGS_DEF = 4;
    localparam int OP_W      = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_RSV5 = 3'd5;
    localparam logic [OP_W-1:0] OP_RSV6 = 3'd6;
    localparam logic [OP_W-1:0] OP_LI   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } ctrl_state_t;

    // LI bypasses the ALU result; everything else retires what the ALU returns.
    function automatic logic is_li(input logic [OP_W-1:0] op);
        return op == OP_LI;
    endfunction

endpackage

// File: rtl/alu_ctrl_rf.sv
// NREGS x WIDTH register file: two combinational operand reads, one debug
// read and a single synchronous write port, cleared by the async reset.
module alu_ctrl_rf
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] regs [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [WIDTH-1:0] r_q;
            logic [WIDTH-1:0] r_d;

            always_comb begin
                r_d = r_q;
                if (we && (waddr == IDX)) begin
                    r_d = wdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= r_d;
                end
            end

            assign regs[gi] = r_q;
        end
    endgenerate

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Three-cycle (IDLE/EXEC/WB) instruction controller driving an external
// combinational ALU and retiring results into a small register file.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OP_W-1:0]  instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             done_valid,
    output logic [AW-1:0]    done_rd,
    output logic [WIDTH-1:0] done_data,
    output logic             done_zero,
    output logic             flag_z,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    ctrl_state_t      state_q, state_d;
    logic             ready_q, ready_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    rs1_q, rs1_d;
    logic [AW-1:0]    rs2_q, rs2_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             done_valid_q, done_valid_d;
    logic [AW-1:0]    done_rd_q, done_rd_d;
    logic [WIDTH-1:0] done_data_q, done_data_d;
    logic             done_zero_q, done_zero_d;
    logic             flag_z_q, flag_z_d;

    logic             accept;
    logic [AW-1:0]    ra_addr, rb_addr;
    logic [WIDTH-1:0] ra_data, rb_data;
    logic             rf_we;

    // Operands are read while the instruction is still on the input bus so the
    // ALU operand registers are loaded on the same edge that enters EXEC.
    assign ra_addr = (state_q == IDLE) ? instr_rs1 : rs1_q;
    assign rb_addr = (state_q == IDLE) ? instr_rs2 : rs2_q;
    assign accept  = instr_valid && ready_q;
    assign rf_we   = (state_q == WB);

    alu_ctrl_rf #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ra_addr),
        .ra_data  (ra_data),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (done_data_q)
    );

    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        op_d         = op_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_op_d     = '0;
        done_valid_d = 1'b0;
        done_rd_d    = '0;
        done_data_d  = '0;
        done_zero_d  = 1'b0;
        flag_z_d     = flag_z_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    op_d     = instr_op;
                    rd_d     = instr_rd;
                    rs1_d    = instr_rs1;
                    rs2_d    = instr_rs2;
                    imm_d    = instr_imm;
                    alu_a_d  = ra_data;
                    alu_b_d  = rb_data;
                    alu_op_d = instr_op;
                    ready_d  = 1'b0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                done_valid_d = 1'b1;
                done_rd_d    = rd_q;
                if (is_li(op_q)) begin
                    done_data_d = imm_q;
                    done_zero_d = (imm_q == '0);
                end else begin
                    done_data_d = alu_result;
                    done_zero_d = alu_zero;
                end
                state_d = WB;
            end
            WB: begin
                flag_z_d = done_zero_q;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            op_q         <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            done_valid_q <= 1'b0;
            done_rd_q    <= '0;
            done_data_q  <= '0;
            done_zero_q  <= 1'b0;
            flag_z_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            done_valid_q <= done_valid_d;
            done_rd_q    <= done_rd_d;
            done_data_q  <= done_data_d;
            done_zero_q  <= done_zero_d;
            flag_z_q     <= flag_z_d;
        end
    end

    assign instr_ready   = ready_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_operation = alu_op_q;
    assign done_valid    = done_valid_q;
    assign done_rd       = done_rd_q;
    assign done_data     = done_data_q;
    assign done_zero     = done_zero_q;
    assign flag_z        = flag_z_q;

endmodule
